mem_arbiter: RTL
================

# mem_arbiter

Two-requester arbiter and burst sequencer in front of the shared byte-addressed main memory. It arbitrates between the instruction-fetch port (I) and the load/store port (D), issues one command per burst, tracks beat count for 1/4/8/16-word accesses and routes read data, write-data handshakes and completion back to the winner. It sits between the fetch/memory pipeline stages and the main memory model.

## Interface
- ADDRESS_SIZE, 32, address width
- DATA_SIZE, 32, data word width
- ACCESS_SIZE, 2, access-size code width

Ports. x is i or d; each requester has an identical set.
- clk  in  1  clock, all logic on posedge
- rst_n  in  1  reset; one clock, reset is synchronous and active-low
- x_req  in  1  request; held with its command until x_gnt
- x_addr  in  ADDRESS_SIZE  start byte address, word aligned
- x_acc_size  in  ACCESS_SIZE  00=1, 01=4, 10=8, 11=16 words
- x_wren  in  1  1=write burst, 0=read burst (d only; i_wren tied 0 by integrator)
- x_wdata  in  DATA_SIZE  current write beat
- x_gnt  out  1  one-cycle pulse: command accepted, beat 0 issued
- x_wready  out  1  x_wdata consumed this cycle
- x_rvalid  out  1  x_rdata valid this cycle
- x_rdata  out  DATA_SIZE  read beat
- x_done  out  1  one-cycle pulse on final beat
- mem_enable  out  1  command strobe to memory
- mem_addr  out  ADDRESS_SIZE  burst start address, held for whole burst
- mem_acc_size  out  ACCESS_SIZE  held for whole burst
- mem_wren  out  1  held for whole burst
- mem_d_in  out  DATA_SIZE  write beat, muxed from owner's x_wdata
- mem_d_out  in  DATA_SIZE  read beat, registered by memory (valid cycle after its beat)
- mem_busy  in  1  memory burst in progress; checked only for protocol error

## Operation
- States: IDLE, BURST, DRAIN.
- IDLE: if any req, pick winner, latch owner/addr/acc_size/wren, drive mem_enable=1, x_gnt=1 for winner, beat counter=0, go BURST. Else all mem_* outputs hold 0.
- BURST: one beat per cycle; counter increments each cycle; beat count N from acc_size. Writes: x_wready=1 every beat cycle including grant cycle, mem_d_in=x_wdata. When counter reaches N-1, go DRAIN.
- DRAIN: one cycle; final read beat returned; then IDLE.
- Reads: x_rvalid=1 for beat k in cycle (grant+k+1), x_rdata=mem_d_out; x_done with final rvalid (in DRAIN).
- Writes: x_done with final wready (last BURST cycle); DRAIN still spent (memory turnaround).
- Non-owner's gnt/wready/rvalid/done always 0; its x_rdata is 0.
- Counter width 4 bits; N-1 max 15, no wrap.
- Requester must hold req and command stable until gnt; it may deassert req in the gnt cycle or later; changes after gnt ignored.
- mem_busy low during BURST beat >0 sets sticky internal error flag (simulation $display only, no port).

## Timing
- Reset values: all outputs 0, state IDLE, counter 0, rr pointer favours D.
- Grant latency: req sampled high in IDLE -> gnt same cycle (combinational from req in IDLE, registered command outputs valid same cycle via latch bypass).
- Burst occupancy: N beat cycles + 1 DRAIN; back-to-back grants every N+1 cycles.
- Single-word read: gnt at T, rvalid/done at T+1, next grant earliest T+2.
- 16-word write: gnt/wready at T..T+15, done at T+15, DRAIN T+16, next grant T+17.
- Requests arriving in BURST/DRAIN wait; no preemption.
- rst_n low mid-burst: next edge forces IDLE, all outputs 0, partial burst abandoned, no done.
- Simultaneous i_req and d_req in IDLE: resolved per Configuration.

## Configuration
- MEM_ARB_ROUND_ROBIN_EN defined: round-robin; pointer flips to the other requester after each grant; on tie the pointed requester wins; after reset D wins first tie.
- Undefined: fixed priority, D always beats I on tie (I may starve while D requests continuously).

## Test plan
- Single read: d_req, addr 0x80020000, acc 00, memory word 0xDEADBEEF -> d_gnt T, d_rvalid+d_done T+1 with 0xDEADBEEF.
- 4-word write: d_wren=1, acc 01, wdata 1,2,3,4 -> d_wready T..T+3, mem_d_in 1..4, d_done T+3, mem_enable only at T.
- 16-word fetch: i_req acc 11 -> 16 consecutive i_rvalid T+1..T+16, i_done at T+16, mem_addr constant throughout.
- Tie: i_req and d_req high continuously, acc 00 -> with _EN grants D,I,D,I every 2 cycles; without _EN D only.
- Reset mid-burst: rst_n low at beat 5 of 8-word read -> next cycle all outputs 0, no done; fresh i_req granted cycle after rst_n high.
- Wait: i_req arrives during 8-word d burst -> i_gnt exactly 1 cycle after d DRAIN begins.

Source files
------------

// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
//
// Two-requester arbiter and burst sequencer in front of the shared main
// memory. The instruction-fetch port (i_*) and the load/store port (d_*)
// compete for the memory. The winner's command is issued as a single
// mem_enable strobe. The burst is then sequenced beat by beat: 1, 4, 8 or
// 16 words. Write handshakes, read data and completion are routed back to
// the owner only.
//
// Burst timeline, for a grant in cycle T and a beat count N:
//   T           : x_gnt, mem_enable, beat 0 (command driven via latch bypass)
//   T+1..T+N-1  : BURST, beats 1..N-1
//   T+N         : DRAIN, final read beat returned / memory turnaround
//   T+N+1       : IDLE, earliest next grant
//
// Configuration macro:
//   MEM_ARB_ROUND_ROBIN_EN  defined   : round-robin on simultaneous requests;
//                                        D wins the first tie after reset
//                           undefined : fixed priority, D beats I on a tie
//
// Ports (x = i or d, identical sets):
//   clk, rst_n      clock, synchronous active-low reset
//   x_req           request, held with its command until x_gnt
//   x_addr          burst start byte address (word aligned)
//   x_acc_size      00=1, 01=4, 10=8, 11=16 words
//   x_wren          1=write burst, 0=read burst
//   x_wdata         current write beat
//   x_gnt           one-cycle pulse: command accepted, beat 0 issued
//   x_wready        x_wdata consumed this cycle
//   x_rvalid        x_rdata valid this cycle
//   x_rdata         read beat (0 when not valid / not owner)
//   x_done          one-cycle pulse on final beat
//   mem_enable      command strobe to memory
//   mem_addr        burst start address, held for the whole burst
//   mem_acc_size    access size, held for the whole burst
//   mem_wren        write flag, held for the whole burst
//   mem_d_in        write beat, muxed from the owner's x_wdata
//   mem_d_out       read beat from memory (registered by memory)
//   mem_busy        memory burst in progress (protocol sanity only)
// -----------------------------------------------------------------------------
module mem_arbiter #(
    parameter int unsigned ADDRESS_SIZE = 32,
    parameter int unsigned DATA_SIZE    = 32,
    parameter int unsigned ACCESS_SIZE  = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,

    // instruction-fetch requester
    input  logic                    i_req,
    input  logic [ADDRESS_SIZE-1:0] i_addr,
    input  logic [ACCESS_SIZE-1:0]  i_acc_size,
    input  logic                    i_wren,
    input  logic [DATA_SIZE-1:0]    i_wdata,
    output logic                    i_gnt,
    output logic                    i_wready,
    output logic                    i_rvalid,
    output logic [DATA_SIZE-1:0]    i_rdata,
    output logic                    i_done,

    // load/store requester
    input  logic                    d_req,
    input  logic [ADDRESS_SIZE-1:0] d_addr,
    input  logic [ACCESS_SIZE-1:0]  d_acc_size,
    input  logic                    d_wren,
    input  logic [DATA_SIZE-1:0]    d_wdata,
    output logic                    d_gnt,
    output logic                    d_wready,
    output logic                    d_rvalid,
    output logic [DATA_SIZE-1:0]    d_rdata,
    output logic                    d_done,

    // main memory
    output logic                    mem_enable,
    output logic [ADDRESS_SIZE-1:0] mem_addr,
    output logic [ACCESS_SIZE-1:0]  mem_acc_size,
    output logic                    mem_wren,
    output logic [DATA_SIZE-1:0]    mem_d_in,
    input  logic [DATA_SIZE-1:0]    mem_d_out,
    input  logic                    mem_busy
);

    localparam int unsigned CNT_W = 4;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_BURST = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    // Latched burst command; own_d=1 means the D port owns the burst.
    typedef struct packed {
        logic [ADDRESS_SIZE-1:0] addr;
        logic [ACCESS_SIZE-1:0]  acc;
        logic                    wren;
        logic                    own_d;
    } cmd_t;

    // Index of the final beat for an access-size code.
    function automatic logic [CNT_W-1:0] last_beat(input logic [ACCESS_SIZE-1:0] acc);
        case (acc)
            ACCESS_SIZE'(0): last_beat = CNT_W'(0);
            ACCESS_SIZE'(1): last_beat = CNT_W'(3);
            ACCESS_SIZE'(2): last_beat = CNT_W'(7);
            default:         last_beat = CNT_W'(15);
        endcase
    endfunction

    state_t           state;
    cmd_t             cmd_q;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] last_q;
    logic             proto_err;

    logic             grant;
    logic             pick_d;
    logic             tie_d;
    cmd_t             sel;
    logic [CNT_W-1:0] sel_last;

    cmd_t             cur;
    logic             active;
    logic             issue;
    logic             last_now;
    logic             wr_beat;
    logic             rd_beat;
    logic             rd_done;

    // Tie-break: which requester wins when both request in the same cycle.
`ifdef MEM_ARB_ROUND_ROBIN_EN
    logic rr_d;
    assign tie_d = rr_d;
`else
    assign tie_d = 1'b1;
`endif

    // Arbitration. The grant is combinational from req while IDLE, so beat 0
    // goes out in the request cycle; it is suppressed while reset is held.
    always_comb begin
        grant     = rst_n && (state == S_IDLE) && (i_req || d_req);
        pick_d    = d_req && (!i_req || tie_d);
        sel.addr  = pick_d ? d_addr     : i_addr;
        sel.acc   = pick_d ? d_acc_size : i_acc_size;
        sel.wren  = pick_d ? d_wren     : i_wren;
        sel.own_d = pick_d;
        sel_last  = last_beat(sel.acc);
    end

    // Output decode. In the grant cycle the fresh command bypasses the latch;
    // afterwards everything comes from the latched command.
    always_comb begin
        cur      = grant ? sel : cmd_q;
        active   = (state != S_IDLE);
        issue    = grant || (state == S_BURST);
        last_now = grant ? (sel_last == '0) : ((state == S_BURST) && (cnt == last_q));
        wr_beat  = issue && cur.wren;
        // read beat k arrives one cycle after it is issued: BURST and DRAIN
        rd_beat  = ((state == S_BURST) || (state == S_DRAIN)) && !cmd_q.wren;
        rd_done  = (state == S_DRAIN) && !cmd_q.wren;

        mem_enable   = grant;
        mem_addr     = (grant || active) ? cur.addr : '0;
        mem_acc_size = (grant || active) ? cur.acc  : '0;
        mem_wren     = (grant || active) ? cur.wren : 1'b0;
        mem_d_in     = wr_beat ? (cur.own_d ? d_wdata : i_wdata) : '0;

        d_gnt    = grant && sel.own_d;
        i_gnt    = grant && !sel.own_d;

        d_wready = wr_beat && cur.own_d;
        i_wready = wr_beat && !cur.own_d;

        d_rvalid = rd_beat && cmd_q.own_d;
        i_rvalid = rd_beat && !cmd_q.own_d;
        d_rdata  = d_rvalid ? mem_d_out : '0;
        i_rdata  = i_rvalid ? mem_d_out : '0;

        d_done   = ((wr_beat && last_now) && cur.own_d)  || (rd_done && cmd_q.own_d);
        i_done   = ((wr_beat && last_now) && !cur.own_d) || (rd_done && !cmd_q.own_d);
    end

    // Burst sequencer state, latched command and beat counter.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            cmd_q     <= '0;
            cnt       <= '0;
            last_q    <= '0;
            proto_err <= 1'b0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
            rr_d      <= 1'b1;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    if (grant) begin
                        cmd_q  <= sel;
                        last_q <= sel_last;
`ifdef MEM_ARB_ROUND_ROBIN_EN
                        rr_d   <= !pick_d;
`endif
                        // beat 0 is issued in the grant cycle itself
                        if (sel_last == '0) begin
                            state <= S_DRAIN;
                            cnt   <= '0;
                        end else begin
                            state <= S_BURST;
                            cnt   <= CNT_W'(1);
                        end
                    end
                end
                S_BURST: begin
                    // memory must still be mid-burst on every beat after beat 0
                    proto_err <= proto_err | !mem_busy;
                    if (cnt == last_q) begin
                        state <= S_DRAIN;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                S_DRAIN: begin
                    state <= S_IDLE;
                    cnt   <= '0;
                end
                default: begin
                    state <= S_IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

endmodule
